// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Byte-stream instruction loader; assembles big-endian words,
//            screens opcodes and writes them sequentially into imem.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    BYTE   = 3'd3,
    WRITE  = 3'd4,
    FINISH = 3'd5,
    ERROR  = 3'd6
  } state_t;

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  state_t           state, state_nx;
  logic [7:0]       len_hi;
  logic [15:0]      len;
  logic [ADDR_W:0]  idx;
  logic [1:0]       byte_cnt;
  logic [31:0]      word;
  logic             xfer;
  logic             op_ok;
  logic [15:0]      len_rx;
  logic [ADDR_W:0]  idx_inc;
  logic             len_too_big;
  logic             last_word;

  assign rx_ready    = (state == LEN_HI) || (state == LEN_LO) || (state == BYTE);
  assign busy        = rx_ready || (state == WRITE);
  assign cpu_hold    = busy || (state == ERROR);
  assign mem_we      = (state == WRITE);
  assign done        = (state == FINISH);
  assign error       = (state == ERROR);
  assign mem_addr    = idx[ADDR_W-1:0];
  assign mem_wdata   = word;

  assign xfer        = rx_valid && rx_ready;
  assign len_rx      = {len_hi, rx_data};
  assign len_too_big = {1'b0, len_rx} > CAPACITY;
  assign idx_inc     = idx + 1'b1;
  assign last_word   = ({{(15 - ADDR_W){1'b0}}, idx_inc} == len);

  // Opcodes understood by the main control decoder.
  always_comb begin
    op_ok = 1'b0;
    case (rx_data[7:2])
      6'd0, 6'd2, 6'd4, 6'd8, 6'd9, 6'd10,
      6'd12, 6'd13, 6'd14, 6'd35, 6'd43: op_ok = 1'b1;
      default:                           op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LEN_HI;
      LEN_HI:  if (xfer) state_nx = LEN_LO;
      LEN_LO:
        if (xfer) begin
          if (len_rx == 16'd0)  state_nx = FINISH;
          else if (len_too_big) state_nx = ERROR;
          else                  state_nx = BYTE;
        end
      BYTE:
        if (xfer) begin
          if (byte_cnt == 2'd0 && !op_ok) state_nx = ERROR;
          else if (byte_cnt == 2'd3)      state_nx = WRITE;
        end
      WRITE:   state_nx = last_word ? FINISH : BYTE;
      FINISH:  state_nx = IDLE;
      ERROR:   if (start) state_nx = LEN_HI;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_hi       <= '0;
      len          <= '0;
      idx          <= '0;
      byte_cnt     <= '0;
      word         <= '0;
      err_code     <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE, ERROR:
          if (start) begin
            idx          <= '0;
            byte_cnt     <= '0;
            err_code     <= '0;
            words_loaded <= '0;
          end
        LEN_HI: if (xfer) len_hi <= rx_data;
        LEN_LO:
          if (xfer) begin
            len <= len_rx;
            if (len_rx != 16'd0 && len_too_big) err_code <= 2'd2;
          end
        BYTE:
          if (xfer) begin
            // A rejected first byte is swallowed without touching the word.
            if (byte_cnt == 2'd0 && !op_ok) begin
              err_code <= 2'd1;
            end else begin
              word     <= {word[23:0], rx_data};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        WRITE: begin
          idx          <= idx_inc;
          words_loaded <= words_loaded + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed self-checking bench with a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;
  logic [39:0] sb[$];
  logic [5:0]  ops [11] = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd9, 6'd10,
                            6'd12, 6'd13, 6'd14, 6'd35, 6'd43};
  logic [31:0] words4 [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_we) begin
      if (sb.size() == 0) check("write_unexpected", {24'd0, mem_addr, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      else                check("write", {24'd0, mem_addr, mem_wdata}, {24'd0, sb.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    rx_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      k++;
      if (k > 50) begin
        check("rx_ready_timeout", {63'd0, rx_ready}, 64'd1);
        break;
      end
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int addr, input int gapmax);
    sb.push_back({addr[7:0], w});
    for (int i = 3; i >= 0; i--)
      send_byte(w[i*8 +: 8], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [5:0] op;
    op = ops[$urandom_range(0, 10)];
    return {op, 26'($urandom)};
  endfunction

  initial begin
    int d0;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, err_code, words_loaded},
          64'd0);
    reset = 1'b0;
    tick();

    // Basic two-word load, with a start pulse mid-session that must be ignored.
    pulse_start();
    check("busy_after_start", {62'd0, busy, cpu_hold}, 64'd3);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h20080005, 0, 0);
    pulse_start();
    send_word(32'h8C090004, 1, 0);
    check("write_cycle_hold", {62'd0, mem_we, cpu_hold}, 64'd3);
    d0 = done_cnt;
    tick();
    check("done_n2", {60'd0, done, cpu_hold, busy, error}, 64'h8);
    check("words_loaded_n2", 64'(words_loaded), 64'd2);
    tick();
    check("done_once_n2", {31'd0, done, 32'(done_cnt - d0)}, 64'd1);

    // Unsupported opcode on the first word.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'hFC, 0);
    check("bad_opcode", {55'd0, error, err_code, rx_ready, cpu_hold, busy, 3'd0}, {55'd0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 3'd0});
    check("bad_opcode_words", 64'(words_loaded), 64'd0);
    tick(); tick();
    check("error_sticky", {61'd0, error, err_code}, 64'h5);
    pulse_start();
    check("error_cleared", {61'd0, error, err_code}, 64'h0);
    check("restart_busy", {63'd0, busy}, 64'd1);

    // Length one past capacity.
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("len_overflow", {60'd0, error, err_code, rx_ready}, {60'd0, 1'b1, 2'd2, 1'b0});

    // Exactly full capacity.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) send_word(rand_word(), i, 0);
    tick();
    check("done_full", {62'd0, done, error}, 64'h2);
    check("words_loaded_full", 64'(words_loaded), 64'd256);
    check("sb_drain_full", 64'(sb.size()), 64'd0);
    tick();

    // Zero-length session.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("done_n0", {61'd0, done, cpu_hold, busy}, 64'h4);
    check("words_loaded_n0", 64'(words_loaded), 64'd0);
    tick();

    // Gap-free then gappy run of the same four words.
    for (int i = 0; i < 4; i++) words4[i] = rand_word();
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start();
      send_byte(8'h00, pass * 2);
      send_byte(8'h04, pass * 2);
      for (int i = 0; i < 4; i++) send_word(words4[i], i, pass * 3);
      tick();
      check("done_n4", {63'd0, done}, 64'd1);
      check("words_loaded_n4", 64'(words_loaded), 64'd4);
      tick();
    end
    check("sb_drain_n4", 64'(sb.size()), 64'd0);

    // Asynchronous reset in the middle of word 0.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h8C, 0);
    send_byte(8'h09, 0);
    #2 reset = 1'b1;
    #1;
    check("async_reset", {rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, err_code, words_loaded},
          64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < 3; i++) send_word(rand_word(), i, 1);
    tick();
    check("done_after_reset", {63'd0, done}, 64'd1);
    check("words_loaded_after_reset", 64'(words_loaded), 64'd3);
    tick();
    check("sb_drain_final", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
